fir_cmem_dbuf: RTL and testbench

//  Double-buffered FP16 coefficient memory for the FIR datapath; successor to the single-bank cload/caddr/cin CMEM.
//  A new coefficient set streams into the shadow bank over a valid/ready handshake while the MAC keeps reading the active bank.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_cmem_bank.sv | 34 +++
 rtl/fir_cmem_dbuf.sv | 194 +++++++++++++++++++
 tb/tb_fir_cmem_dbuf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient memory.
//   FP_EW / FP_MW / FP_DW : stored float format {sign, exp[FP_EW], man[FP_MW]}
//   cmem_state_e          : coefficient loader FSM states
//   is_denorm()           : true for a subnormal word (exp == 0, mantissa != 0)
package fir_pkg;

    localparam int unsigned FP_EW = 5;
    localparam int unsigned FP_MW = 10;
    localparam int unsigned FP_DW = 1 + FP_EW + FP_MW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StLoad = ST_LOAD,
        StPend = ST_PEND
    } cmem_state_e;

    // +/-0 has a zero mantissa and is deliberately not a denormal.
    function automatic logic is_denorm(input logic [FP_DW-1:0] w);
        return (w[FP_DW-2 -: FP_EW] == '0) && (w[FP_MW-1:0] != '0);
    endfunction

endpackage

// File: rtl/fir_cmem_bank.sv
// One coefficient bank: TAPS x DW, synchronous write, combinational read.
// The read port is registered by the parent so the bank-select mux sits
// in front of a single output register.
//   clk    : clock
//   we     : write enable
//   waddr  : write address (always < TAPS)
//   wdata  : write data
//   raddr  : read address; addresses >= TAPS read as zero
//   rdata  : read data
module fir_cmem_bank #(
    parameter int unsigned TAPS = 65,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [TAPS];

    // No reset: contents survive rst, only the control state is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < TAPS) ? mem[raddr] : '0;

endmodule

// File: rtl/fir_cmem_dbuf.sv
// Double-buffered FP16 coefficient memory for the FIR datapath.
// A new coefficient set streams into the shadow bank (the one not being read)
// over a valid/ready handshake. Once all TAPS words are in, the banks swap on
// the next sample_tick, so one output sample never mixes old and new taps.
// Denormal coefficients are counted and, with FLUSH_DENORM, stored as signed zero.
//   clk         : clock
//   rst         : synchronous active-high reset
//   load_start  : begin/restart loading the shadow bank at address 0
//   load_valid  : load_data valid
//   load_data   : coefficient word, ascending address order
//   load_ready  : shadow bank accepting data
//   sample_tick : one-cycle strobe per input sample
//   rd_addr     : MAC read address into the active bank
//   rd_data     : registered read data, 1-cycle latency
//   active_bank : bank currently serving reads
//   swap_pend   : full set loaded, waiting for sample_tick
//   load_done   : one-cycle pulse in the cycle after the swap
//   load_abort  : one-cycle pulse after load_start interrupts a load or pending swap
//   denorm_cnt  : denormals seen in the set most recently swapped in
module fir_cmem_dbuf
    import fir_pkg::*;
#(
    parameter int unsigned TAPS         = 65,
    parameter int unsigned EW           = FP_EW,
    parameter int unsigned MW           = FP_MW,
    parameter int unsigned DW           = 1 + EW + MW,
    parameter int unsigned AW           = $clog2(TAPS),
    parameter bit          FLUSH_DENORM = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          sample_tick,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          active_bank,
    output logic          swap_pend,
    output logic          load_done,
    output logic          load_abort,
    output logic [AW:0]   denorm_cnt
);

    cmem_state_e   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   dacc_q, dacc_d;
    logic [AW:0]   denorm_cnt_q, denorm_cnt_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] rd_data_q;

    logic          wr_en;
    logic          wr_denorm;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rdata0, rdata1;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign wr_denorm = is_denorm(load_data);
    assign wr_data   = (FLUSH_DENORM && wr_denorm) ? {load_data[DW-1], {(EW + MW){1'b0}}}
                                                    : load_data;

    // load_start restarts the set, so a coincident word is dropped.
    assign wr_en = (state_q == StLoad) && load_valid && !load_start;

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        dacc_d       = dacc_q;
        active_d     = active_q;
        denorm_cnt_d = denorm_cnt_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A sample_tick here has nothing to swap and is ignored.
                if (load_start) begin
                    state_d = StLoad;
                    wptr_d  = '0;
                    dacc_d  = '0;
                end
            end

            StLoad: begin
                if (load_start) begin
                    abort_d = 1'b1;
                    wptr_d  = '0;
                    dacc_d  = '0;
                end else if (wr_en) begin
                    dacc_d = dacc_q + {{AW{1'b0}}, wr_denorm};
                    // A tick coinciding with the final write is not
                    // consumed; the swap waits for the next one.
                    if (wptr_q == AW'(TAPS - 1)) begin
                        wptr_d  = '0;
                        state_d = StPend;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end

            StPend: begin
                if (load_start) begin
                    abort_d = 1'b1;
                    state_d = StLoad;
                    wptr_d  = '0;
                    dacc_d  = '0;
                end else if (sample_tick) begin
                    active_d     = ~active_q;
                    denorm_cnt_d = dacc_q;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            dacc_q       <= '0;
            denorm_cnt_q <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            dacc_q       <= dacc_d;
            denorm_cnt_q <= denorm_cnt_d;
            active_q     <= active_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            // Uses the bank selected before any swap in this cycle, so a read
            // issued in the swap cycle still returns the old set.
            rd_data_q    <= active_q ? rdata1 : rdata0;
        end
    end

    // ------------------------------------------------------------------
    // Banks: writes always target the shadow bank (~active)
    // ------------------------------------------------------------------
    fir_cmem_bank #(
        .TAPS (TAPS),
        .DW   (DW),
        .AW   (AW)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_en && active_q),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fir_cmem_bank #(
        .TAPS (TAPS),
        .DW   (DW),
        .AW   (AW)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_en && !active_q),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_ready  = (state_q == StLoad);
    assign swap_pend   = (state_q == StPend);
    assign rd_data     = rd_data_q;
    assign active_bank = active_q;
    assign load_done   = done_q;
    assign load_abort  = abort_q;
    assign denorm_cnt  = denorm_cnt_q;

endmodule

// File: tb/tb_fir_cmem_dbuf.sv
// Bench for fir_cmem_dbuf: table-driven read vectors, a read scoreboard fed
// from a bank model, and hand-written sequences for swap/abort/reset corners.
module tb_fir_cmem_dbuf;

    localparam int unsigned TAPS = 65;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          sample_tick;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          active_bank;
    logic          swap_pend;
    logic          load_done;
    logic          load_abort;
    logic [AW:0]   denorm_cnt;

    always #5 clk = ~clk;

    fir_cmem_dbuf #(
        .TAPS         (TAPS),
        .FLUSH_DENORM (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .sample_tick (sample_tick),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .active_bank (active_bank),
        .swap_pend   (swap_pend),
        .load_done   (load_done),
        .load_abort  (load_abort),
        .denorm_cnt  (denorm_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t       rd_vecs [6];
    int            checks    = 0;
    int            errors    = 0;
    int            done_cnt  = 0;
    int            abort_cnt = 0;
    int            ready_cnt = 0;
    logic [DW-1:0] rd_q [$];
    logic [DW-1:0] mdl_bank [2][TAPS];
    logic          mdl_active;
    logic [DW-1:0] set_w [TAPS];
    bit            chk_rd  = 1'b0;
    bit            rd_walk = 1'b0;

    always @(negedge clk) begin
        if (load_done)  done_cnt++;
        if (load_abort) abort_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] flushed(input logic [DW-1:0] w);
        if (w[14:10] == 5'd0 && w[9:0] != 10'd0) return {w[15], 15'd0};
        return w;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a >= TAPS) return '0;
        return mdl_bank[mdl_active][a];
    endfunction

    // One clock; expected read data is queued before the edge and compared after.
    task automatic step();
        if (chk_rd) rd_q.push_back(model_read(rd_addr));
        @(posedge clk);
        #1;
        if (rd_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        if (rd_walk) rd_addr = (rd_addr == AW'(TAPS - 1)) ? '0 : rd_addr + 1'b1;
    endtask

    task automatic start_load(input bit with_valid);
        load_start = 1'b1;
        load_valid = with_valid;
        load_data  = 16'hFFFF;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic write_words(input int n, input bit tick_last);
        for (int i = 0; i < n; i++) begin
            load_valid  = 1'b1;
            load_data   = set_w[i];
            sample_tick = tick_last && (i == n - 1);
            if (load_ready) ready_cnt++;
            mdl_bank[!mdl_active][i] = flushed(set_w[i]);
            step();
        end
        load_valid  = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic do_swap(input logic [AW:0] exp_dcnt);
        int d0;
        d0 = done_cnt;
        chk("swap_pend before tick", 32'(swap_pend), 32'd1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        mdl_active  = !mdl_active;
        chk("active_bank after swap", 32'(active_bank), 32'(mdl_active));
        chk("load_done after swap", 32'(load_done), 32'd1);
        chk("swap_pend after swap", 32'(swap_pend), 32'd0);
        chk("denorm_cnt after swap", 32'(denorm_cnt), 32'(exp_dcnt));
        step();
        chk("load_done one cycle", 32'(load_done), 32'd0);
        chk("load_done pulse count", done_cnt, d0 + 1);
    endtask

    task automatic read_const(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        rd_q.push_back(exp);
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " active_bank"}, 32'(active_bank), 32'd0);
        chk({tag, " load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, " swap_pend"}, 32'(swap_pend), 32'd0);
        chk({tag, " load_done"}, 32'(load_done), 32'd0);
        chk({tag, " load_abort"}, 32'(load_abort), 32'd0);
        chk({tag, " denorm_cnt"}, 32'(denorm_cnt), 32'd0);
        chk({tag, " rd_data"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        int d0;
        int a0;

        rd_vecs[0] = '{addr: 7'd0,   exp: 16'h3C00};
        rd_vecs[1] = '{addr: 7'd5,   exp: 16'h3C05};
        rd_vecs[2] = '{addr: 7'd33,  exp: 16'h3C21};
        rd_vecs[3] = '{addr: 7'd64,  exp: 16'h3C40};
        rd_vecs[4] = '{addr: 7'd65,  exp: 16'h0000};
        rd_vecs[5] = '{addr: 7'd127, exp: 16'h0000};

        rst         = 1'b1;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        sample_tick = 1'b0;
        rd_addr     = '0;
        mdl_active  = 1'b0;

        // Reset state
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // 1: basic load, swap and table-driven readback
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h3C00 + 16'(i);
        start_load(1'b0);
        ready_cnt = 0;
        write_words(TAPS, 1'b0);
        chk("t1 load_ready cycles", ready_cnt, TAPS);
        chk("t1 load_ready in pend", 32'(load_ready), 32'd0);
        do_swap('0);
        chk("t1 active_bank", 32'(active_bank), 32'd1);
        for (int k = 0; k < 6; k++) read_const(rd_vecs[k].addr, rd_vecs[k].exp);

        // 2: denormal counting and flush
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h4000 + 16'(i);
        set_w[10] = 16'h0001;
        set_w[20] = 16'h8200;
        set_w[30] = 16'h8000;
        start_load(1'b0);
        write_words(TAPS, 1'b0);
        do_swap(8'd2);
        read_const(7'd10, 16'h0000);
        read_const(7'd20, 16'h8000);
        read_const(7'd30, 16'h8000);
        read_const(7'd11, 16'h400B);

        // 3: continuous reads across a reload and swap
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h5000 + 16'(i);
        rd_addr = '0;
        chk_rd  = 1'b1;
        rd_walk = 1'b1;
        start_load(1'b0);
        write_words(TAPS, 1'b0);
        step();
        step();
        do_swap('0);
        for (int i = 0; i < 4; i++) step();
        chk_rd  = 1'b0;
        rd_walk = 1'b0;

        // 4: tick coinciding with the final write is not consumed
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h6000 + 16'(i);
        start_load(1'b0);
        write_words(TAPS, 1'b1);
        d0 = done_cnt;
        chk("t4 swap_pend after last write", 32'(swap_pend), 32'd1);
        chk("t4 active_bank held", 32'(active_bank), 32'(mdl_active));
        step();
        step();
        step();
        chk("t4 still pending", 32'(swap_pend), 32'd1);
        chk("t4 no early load_done", done_cnt, d0);
        do_swap('0);
        read_const(7'd7, 16'h6007);

        // 5: abort mid-load and during pend, then full reload
        a0 = abort_cnt;
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h0001 + 16'(i);
        start_load(1'b0);
        write_words(30, 1'b0);
        chk("t5 load_ready at wptr 30", 32'(load_ready), 32'd1);
        start_load(1'b1);
        chk("t5 load_ready after abort", 32'(load_ready), 32'd1);
        chk("t5 active_bank after abort1", 32'(active_bank), 32'(mdl_active));
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h0200;
        write_words(TAPS, 1'b0);
        chk("t5 pend before abort2", 32'(swap_pend), 32'd1);
        start_load(1'b0);
        chk("t5 swap_pend after abort2", 32'(swap_pend), 32'd0);
        chk("t5 active_bank after abort2", 32'(active_bank), 32'(mdl_active));
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h7000 + 16'(i);
        set_w[64] = 16'h03FF;
        write_words(TAPS, 1'b0);
        chk("t5 load_abort pulses", abort_cnt, a0 + 2);
        do_swap(8'd1);
        read_const(7'd64, 16'h0000);
        read_const(7'd63, 16'h703F);

        // 6: reset while a swap is pending
        for (int i = 0; i < TAPS; i++) set_w[i] = 16'h2000 + 16'(i);
        start_load(1'b0);
        write_words(TAPS, 1'b0);
        chk("t6 pend before reset", 32'(swap_pend), 32'd1);
        d0          = done_cnt;
        rst         = 1'b1;
        sample_tick = 1'b1;
        step();
        chk_reset_outputs("t6 reset");
        rst         = 1'b0;
        sample_tick = 1'b0;
        mdl_active  = 1'b0;
        step();
        step();
        step();
        chk("t6 no load_done after reset", done_cnt, d0);
        chk("t6 active_bank idle", 32'(active_bank), 32'd0);
        chk("t6 swap_pend idle", 32'(swap_pend), 32'd0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("t6 idle tick no swap", 32'(active_bank), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
